rtc_stopwatch: RTL and testbench

RTC_STOPWATCH -- requirements
Module: rtc_stopwatch

---
 rtl/rtc_stopwatch_pkg.sv | 40 ++++
 rtl/rtc_bcd_inc.sv | 37 +++
 rtl/rtc_stopwatch.sv | 119 +++++++++++
 tb/tb_rtc_stopwatch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_stopwatch_pkg.sv
// Shared constants and types for the RTC stopwatch: BCD field offsets,
// control-word bit indices and the status-word layout. The same offsets and
// indices are mirrored in the rtctimer software headers, so keep them in sync.
package rtc_stopwatch_pkg;

  // Packed BCD time layout: hh:mm:ss, one byte per field.
  localparam int BCD_W   = 24;
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 8;
  localparam int HR_LSB  = 16;

  // Control word bit indices (i_data).
  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_RUN   = 1;
  localparam int CTRL_LAP   = 2;

  // Last representable time before the counter wraps back to 00:00:00.
  localparam logic [BCD_W-1:0] BCD_MAX = 24'h99_59_59;

  // Status word returned on o_data.
  typedef struct packed {
    logic [5:0]       rsvd;
    logic             overflow;
    logic             running;
    logic [BCD_W-1:0] bcd_time;
  } status_t;

  // Increment one BCD digit when carry_in is set; returns {carry_out, digit}.
  // A digit equal to max_val rolls over to zero and carries.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit,
                                               input logic [3:0] max_val,
                                               input logic       carry_in);
    logic [4:0] res;
    if (!carry_in)             res = {1'b0, digit};
    else if (digit == max_val) res = {1'b1, 4'h0};
    else                       res = {1'b0, digit + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/rtc_bcd_inc.sv
// Combinational +1 second incrementer for a packed BCD hh:mm:ss value.
// Seconds and minutes roll at 59, hours at 99; wrap_o flags 99:59:59 -> 00:00:00.
// Being purely combinational from the current time, it stays exact for
// back-to-back increments on consecutive cycles.
module rtc_bcd_inc
  import rtc_stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] time_i,
  output logic [BCD_W-1:0] time_o,
  output logic             wrap_o
);

  // Each entry is {carry_out, digit}; the carry ripples from seconds upward.
  logic [4:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;

  assign sec_lo = bcd_digit_inc(time_i[SEC_LSB   +: 4], 4'd9, 1'b1);
  assign sec_hi = bcd_digit_inc(time_i[SEC_LSB+4 +: 4], 4'd5, sec_lo[4]);
  assign min_lo = bcd_digit_inc(time_i[MIN_LSB   +: 4], 4'd9, sec_hi[4]);
  assign min_hi = bcd_digit_inc(time_i[MIN_LSB+4 +: 4], 4'd5, min_lo[4]);
  assign hr_lo  = bcd_digit_inc(time_i[HR_LSB    +: 4], 4'd9, min_hi[4]);
  assign hr_hi  = bcd_digit_inc(time_i[HR_LSB+4  +: 4], 4'd9, hr_lo[4]);

  // Reassemble the digits into the packed layout; tens digits of seconds and
  // minutes never exceed 5, so bits 7 and 15 stay zero.
  always_comb begin
    time_o                    = '0;
    time_o[SEC_LSB   +: 4]    = sec_lo[3:0];
    time_o[SEC_LSB+4 +: 4]    = sec_hi[3:0];
    time_o[MIN_LSB   +: 4]    = min_lo[3:0];
    time_o[MIN_LSB+4 +: 4]    = min_hi[3:0];
    time_o[HR_LSB    +: 4]    = hr_lo[3:0];
    time_o[HR_LSB+4  +: 4]    = hr_hi[3:0];
  end

  assign wrap_o = hr_hi[4];

endmodule

// File: rtl/rtc_stopwatch.sv
// RTC stopwatch: counts 2^LGSUBCK sub-second strobes per second into a packed
// BCD hh:mm:ss time, with run/stop, clear, lap capture, a sticky overflow flag
// and a one-cycle interrupt on wrap past 99:59:59. LGSUBCK is legal in 1..8.
module rtc_stopwatch
  import rtc_stopwatch_pkg::*;
#(
  parameter int LGSUBCK = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sub_ck,
  input  logic        i_wr,
  input  logic [2:0]  i_data,
  output logic [31:0] o_data,
  output logic [31:0] o_lap,
  output logic        o_interrupt
);

  logic [LGSUBCK-1:0] sub_q, sub_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               running_q, running_d;
  logic               overflow_q, overflow_d;
  logic [LGSUBCK-1:0] lap_sub_q, lap_sub_d;
  logic [BCD_W-1:0]   lap_bcd_q, lap_bcd_d;
  logic               irq_q, irq_d;

  logic [BCD_W-1:0]   bcd_inc;
  logic               bcd_wrap;
  logic               sub_adv;
  logic               tick;
  logic               wr_clear;
  logic               wr_lap;

  assign wr_clear = i_wr && i_data[CTRL_CLEAR];
  assign wr_lap   = i_wr && i_data[CTRL_LAP];
  assign sub_adv  = i_sub_ck && running_q;
  // A second elapses on the strobe that wraps the sub-second counter.
  assign tick     = sub_adv && (sub_q == '1);

  rtc_bcd_inc u_bcd_inc (
    .time_i (bcd_q),
    .time_o (bcd_inc),
    .wrap_o (bcd_wrap)
  );

  // Next-state logic: clear beats tick; lap always samples the pre-edge value.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    sub_d      = sub_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    lap_sub_d  = lap_sub_q;
    lap_bcd_d  = lap_bcd_q;
    irq_d      = 1'b0;
    // Run state follows the write; a stop in the same cycle as a tick still
    // lets that tick land because the tick uses the pre-edge running_q.
    running_d  = i_wr ? i_data[CTRL_RUN] : running_q;

    if (wr_clear) begin
      sub_d      = '0;
      bcd_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (sub_adv) sub_d = sub_q + 1'b1;
      if (tick) begin
        bcd_d = bcd_inc;
        if (bcd_wrap) begin
          overflow_d = 1'b1;
          irq_d      = 1'b1;
        end
      end
    end

    if (wr_lap) begin
      lap_sub_d = sub_q;
      lap_bcd_d = bcd_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      sub_q      <= '0;
      bcd_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      lap_sub_q  <= '0;
      lap_bcd_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      sub_q      <= sub_d;
      bcd_q      <= bcd_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
      lap_sub_q  <= lap_sub_d;
      lap_bcd_q  <= lap_bcd_d;
      irq_q      <= irq_d;
    end
  end

  status_t    status;
  logic [7:0] lap_sub_ext;

  // Output packing: status word and zero-extended lap sub-second count.
  always_comb begin
    status          = '0;
    status.overflow = overflow_q;
    status.running  = running_q;
    status.bcd_time = bcd_q;
    lap_sub_ext                = '0;
    lap_sub_ext[LGSUBCK-1:0]   = lap_sub_q;
  end

  assign o_data      = status;
  assign o_lap       = {lap_sub_ext, lap_bcd_q};
  assign o_interrupt = irq_q;

endmodule

// File: tb/tb_rtc_stopwatch.sv
// Directed scoreboard bench for rtc_stopwatch (LGSUBCK=2). Stimulus pushes
// hand-computed expectations into a queue; a monitor on the falling edge pops
// and compares them against the registered outputs.
module tb_rtc_stopwatch;
  import rtc_stopwatch_pkg::*;

  logic        i_clk    = 1'b0;
  logic        i_reset  = 1'b0;
  logic        i_sub_ck = 1'b0;
  logic        i_wr     = 1'b0;
  logic [2:0]  i_data   = 3'b000;
  logic [31:0] o_data;
  logic [31:0] o_lap;
  logic        o_interrupt;

  rtc_stopwatch #(.LGSUBCK(2)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_sub_ck    (i_sub_ck),
    .i_wr        (i_wr),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_lap       (o_lap),
    .o_interrupt (o_interrupt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] lap;
    logic        intr;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [23:0] preset_val  = '0;
  logic [31:0] lap_e       = '0;

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge i_clk) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (o_data !== e.data || o_lap !== e.lap || o_interrupt !== e.intr) begin
        miscompares++;
        $display("FAIL %s: got data=%h lap=%h irq=%b, want data=%h lap=%h irq=%b",
                 n, o_data, o_lap, o_interrupt, e.data, e.lap, e.intr);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic sub, input logic wr, input logic [2:0] data,
                      input logic rst);
    i_sub_ck = sub;
    i_wr     = wr;
    i_data   = data;
    i_reset  = rst;
    @(posedge i_clk);
    #1;
    i_sub_ck = 1'b0;
    i_wr     = 1'b0;
    i_data   = 3'b000;
    i_reset  = 1'b0;
  endtask

  task automatic run_sub(input int n);
    repeat (n) step(1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] data,
                            input logic intr);
    exp_t e;
    e.data = data;
    e.lap  = lap_e;
    e.intr = intr;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge i_clk);
    #1;
  endtask

  // Load the time register directly while stopped, to reach late times quickly.
  task automatic preset(input logic [23:0] v);
    preset_val = v;
    force dut.bcd_q = preset_val;
    @(posedge i_clk);
    #1;
    release dut.bcd_q;
  endtask

  initial begin
    // Reset state.
    step(1'b0, 1'b0, 3'b000, 1'b1);
    expect_out("reset", 32'h0000_0000, 1'b0);

    // Start, then four sub-second strobes make one second.
    step(1'b0, 1'b1, 3'b010, 1'b0);
    expect_out("run", 32'h0100_0000, 1'b0);
    run_sub(3);
    expect_out("sub3", 32'h0100_0000, 1'b0);
    run_sub(1);
    expect_out("first_sec", 32'h0100_0001, 1'b0);

    // Plain stop, then strobes while stopped change nothing.
    step(1'b0, 1'b1, 3'b000, 1'b0);
    expect_out("stop", 32'h0000_0001, 1'b0);
    run_sub(8);
    expect_out("stopped_hold", 32'h0000_0001, 1'b0);

    // Clear+run, count to the seconds-to-minutes carry.
    step(1'b0, 1'b1, 3'b011, 1'b0);
    expect_out("clear_run", 32'h0100_0000, 1'b0);
    run_sub(239);
    expect_out("s59", 32'h0100_0059, 1'b0);
    run_sub(1);
    expect_out("min_carry", 32'h0100_0100, 1'b0);

    // Lap coincident with the tick at 00:01:30 captures the pre-increment value.
    run_sub(123);
    expect_out("s130", 32'h0100_0130, 1'b0);
    step(1'b1, 1'b1, 3'b110, 1'b0);
    lap_e = 32'h0300_0130;
    expect_out("lap_tick", 32'h0100_0131, 1'b0);

    // Tick and stop in the same cycle still increments.
    run_sub(3);
    step(1'b1, 1'b1, 3'b000, 1'b0);
    expect_out("tick_stop", 32'h0000_0132, 1'b0);
    run_sub(4);
    expect_out("stopped_hold2", 32'h0000_0132, 1'b0);

    // Clear+run coincident with the tick at 00:00:07: clear wins.
    step(1'b0, 1'b1, 3'b011, 1'b0);
    expect_out("clear_run2", 32'h0100_0000, 1'b0);
    run_sub(31);
    expect_out("s7", 32'h0100_0007, 1'b0);
    step(1'b1, 1'b1, 3'b011, 1'b0);
    expect_out("clear_tick", 32'h0100_0000, 1'b0);
    run_sub(1);
    step(1'b0, 1'b1, 3'b110, 1'b0);
    lap_e = 32'h0100_0000;
    expect_out("lap_sub_after_clear", 32'h0100_0000, 1'b0);

    // Lap coincident with clear captures the pre-clear sub count.
    run_sub(1);
    step(1'b0, 1'b1, 3'b111, 1'b0);
    lap_e = 32'h0200_0000;
    expect_out("lap_clear", 32'h0100_0000, 1'b0);

    // Hours tens carry 09:59:59 -> 10:00:00.
    step(1'b0, 1'b1, 3'b000, 1'b0);
    expect_out("stop2", 32'h0000_0000, 1'b0);
    preset(24'h09_59_59);
    expect_out("preset_h9", 32'h0009_5959, 1'b0);
    step(1'b0, 1'b1, 3'b010, 1'b0);
    run_sub(4);
    expect_out("hour_tens", 32'h0110_0000, 1'b0);

    // Wrap at 99:59:59 with a strobe every cycle.
    step(1'b0, 1'b1, 3'b000, 1'b0);
    expect_out("stop3", 32'h0010_0000, 1'b0);
    preset(24'h99_59_50);
    expect_out("preset_wrap", 32'h0099_5950, 1'b0);
    step(1'b0, 1'b1, 3'b010, 1'b0);
    run_sub(39);
    expect_out("pre_wrap", 32'h0199_5959, 1'b0);
    run_sub(1);
    expect_out("wrap", 32'h0300_0000, 1'b1);
    run_sub(1);
    expect_out("irq_once", 32'h0300_0000, 1'b0);
    run_sub(3);
    expect_out("post_wrap", 32'h0300_0001, 1'b0);

    // Clear drops overflow; count to 00:12:34, then reset mid-count with a write.
    step(1'b0, 1'b1, 3'b011, 1'b0);
    expect_out("clear_ovf", 32'h0100_0000, 1'b0);
    run_sub(3016);
    expect_out("t1234", 32'h0100_1234, 1'b0);
    step(1'b1, 1'b1, 3'b010, 1'b1);
    lap_e = 32'h0000_0000;
    expect_out("reset_mid", 32'h0000_0000, 1'b0);
    run_sub(4);
    expect_out("reset_holds", 32'h0000_0000, 1'b0);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
